udma_l2_responder: RTL

L2 memory-side responder for the uDMA core's two L2 ports. It serves the RX write port and the TX read port from one single-ported word-organised memory array, with one access granted per cycle. Both ports use TCDM-style req/gnt, and the TX port adds an rvalid response. The block sits between `udma_core` and L2 in subsystem integration and in the uDMA verification bench, where it is the reference L2 model.

---
 rtl/udma_l2_responder.sv | 107 ++++++++++
 1 files changed

// File: rtl/udma_l2_responder.sv
// L2 responder for the uDMA RX write / TX read ports sharing one single-ported
// word memory. Round-robin arbitration, one access per cycle, 1-cycle read latency.
module udma_l2_responder #(
  parameter int unsigned L2_DATA_WIDTH = 32,
  parameter int unsigned MEM_DEPTH     = 4096,
  parameter logic [31:0] BASE_ADDR     = 32'h1C00_0000,
  parameter logic [31:0] ERR_RDATA     = 32'hBADACCE5
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic                       rx_l2_req_i,
  output logic                       rx_l2_gnt_o,
  input  logic [31:0]                rx_l2_addr_i,
  input  logic [L2_DATA_WIDTH/8-1:0] rx_l2_be_i,
  input  logic [L2_DATA_WIDTH-1:0]   rx_l2_wdata_i,
  input  logic                       tx_l2_req_i,
  output logic                       tx_l2_gnt_o,
  input  logic [31:0]                tx_l2_addr_i,
  output logic [L2_DATA_WIDTH-1:0]   tx_l2_rdata_o,
  output logic                       tx_l2_rvalid_o,
  input  logic                       stall_i,
  output logic                       err_o
);

  localparam int          BeWidth  = int'(L2_DATA_WIDTH / 8);
  localparam int unsigned OffBits  = $clog2(L2_DATA_WIDTH / 8);
  localparam int unsigned IdxBits  = $clog2(MEM_DEPTH);
  localparam logic [31:0] MemBytes = 32'(MEM_DEPTH * (L2_DATA_WIDTH / 8));
  localparam logic [L2_DATA_WIDTH-1:0] ErrWord = {(L2_DATA_WIDTH / 32){ERR_RDATA}};

  logic [L2_DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  logic                     prio_q, prio_d;
  logic                     rvalid_q;
  logic [L2_DATA_WIDTH-1:0] rdata_q;
  logic                     err_q;

  logic [31:0]              rx_off, tx_off;
  logic                     rx_in_range, tx_in_range;
  logic [IdxBits-1:0]       rx_idx, tx_idx;
  logic                     rx_gnt, tx_gnt;

  // Address decode: wrapping subtract makes addresses below the base huge, hence out of range
  always_comb begin
    rx_off      = rx_l2_addr_i - BASE_ADDR;
    tx_off      = tx_l2_addr_i - BASE_ADDR;
    rx_in_range = (rx_off < MemBytes);
    tx_in_range = (tx_off < MemBytes);
    rx_idx      = rx_off[OffBits +: IdxBits];
    tx_idx      = tx_off[OffBits +: IdxBits];
  end

  // Grants: prio_q = 0 favours RX on conflict, 1 favours TX; nothing granted in reset/stall
  always_comb begin
    rx_gnt = 1'b0;
    tx_gnt = 1'b0;
    if (rstn_i && !stall_i) begin
      rx_gnt = rx_l2_req_i && (!tx_l2_req_i || !prio_q);
      tx_gnt = tx_l2_req_i && (!rx_l2_req_i ||  prio_q);
    end
  end

  // Next priority: point away from whichever port was just served
  always_comb begin
    prio_d = prio_q;
    if (rx_gnt) begin
      prio_d = 1'b1;
    end else if (tx_gnt) begin
      prio_d = 1'b0;
    end
  end

  // Control and read-response registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      prio_q   <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      prio_q   <= prio_d;
      rvalid_q <= tx_gnt;
      err_q    <= (rx_gnt && !rx_in_range) || (tx_gnt && !tx_in_range);
      if (tx_gnt) begin
        rdata_q <= tx_in_range ? mem_q[tx_idx] : ErrWord;
      end
    end
  end

  // Byte-lane masked memory write; contents are intentionally not reset
  always_ff @(posedge clk_i) begin
    if (rx_gnt && rx_in_range) begin
      for (int b = 0; b < BeWidth; b++) begin
        if (rx_l2_be_i[b]) begin
          mem_q[rx_idx][8*b +: 8] <= rx_l2_wdata_i[8*b +: 8];
        end
      end
    end
  end

  assign rx_l2_gnt_o    = rx_gnt;
  assign tx_l2_gnt_o    = tx_gnt;
  assign tx_l2_rdata_o  = rdata_q;
  assign tx_l2_rvalid_o = rvalid_q;
  assign err_o          = err_q;

endmodule
